// File: rtl/reg_file_16b_scb_pkg.sv
// reg_file_16b_scb_pkg: shared widths and word/address types for the register file
package reg_file_16b_scb_pkg;
  localparam int DATA_W = 16;
  localparam int NREG = 8;
  localparam int ADDR_W = 3;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/reg_file_16b_scb_if.sv
// reg_file_16b_scb_if: read/write/issue bus plus stall, busy and err status of the register file
interface reg_file_16b_scb_if;
  import reg_file_16b_scb_pkg::*;
  addr_t rd_addr1;
  addr_t rd_addr2;
  logic rd_use1;
  logic rd_use2;
  data_t rd_data1;
  data_t rd_data2;
  logic wr_en;
  addr_t wr_addr;
  data_t wr_data;
  logic iss_en;
  addr_t iss_addr;
  logic stall;
  logic [NREG-1:0] busy;
  logic err;
  modport slave (
    input rd_addr1, rd_addr2, rd_use1, rd_use2, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data1, rd_data2, stall, busy, err
  );
  modport master (
    output rd_addr1, rd_addr2, rd_use1, rd_use2, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input rd_data1, rd_data2, stall, busy, err
  );
endinterface

// File: rtl/reg_file_16b_scb_scoreboard.sv
// reg_scoreboard: pending-write bits, RAW stall and sticky writeback error; ports: read/use, writeback, issue in; stall_o, busy_o, err_o out
module reg_scoreboard
  import reg_file_16b_scb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  addr_t           rd_addr1_i,
  input  addr_t           rd_addr2_i,
  input  logic            rd_use1_i,
  input  logic            rd_use2_i,
  input  logic            wr_en_i,
  input  addr_t           wr_addr_i,
  input  logic            iss_en_i,
  input  addr_t           iss_addr_i,
  output logic            stall_o,
  output logic [NREG-1:0] busy_o,
  output logic            err_o
);
  logic [NREG-1:0] busy_q, busy_d, set_v, clr_v;
  logic err_q, err_d, stall;
  always_comb begin
    stall = (rd_use1_i & busy_q[rd_addr1_i] & ~(wr_en_i & (wr_addr_i == rd_addr1_i)))
          | (rd_use2_i & busy_q[rd_addr2_i] & ~(wr_en_i & (wr_addr_i == rd_addr2_i)));
    set_v = (iss_en_i & ~stall) ? NREG'(1) << iss_addr_i : '0;
    clr_v = wr_en_i ? NREG'(1) << wr_addr_i : '0;
    // a new producer supersedes the one whose writeback lands this cycle
    busy_d = set_v | (busy_q & ~clr_v);
    err_d = err_q | (wr_en_i & ~busy_q[wr_addr_i] & ~set_v[wr_addr_i]);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      err_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q <= err_d;
    end
  end
  assign stall_o = stall;
  assign busy_o = busy_q;
  assign err_o = err_q;
endmodule

// File: rtl/reg_file_16b_scb.sv
// reg_file_16b_scb: 8x16 register file with bypassed reads and pending-write scoreboard; ports: clk, rst, rf_io (slave bus)
module reg_file_16b_scb
  import reg_file_16b_scb_pkg::*;
(
  input logic clk,
  input logic rst,
  reg_file_16b_scb_if.slave rf_io
);
  data_t regs_q [NREG];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (rf_io.wr_en) begin
      regs_q[rf_io.wr_addr] <= rf_io.wr_data;
    end
  end
  // writeback data is forwarded so a reader sees it in the same cycle
  always_comb begin
    rf_io.rd_data1 = (rf_io.wr_en && rf_io.wr_addr == rf_io.rd_addr1) ? rf_io.wr_data : regs_q[rf_io.rd_addr1];
    rf_io.rd_data2 = (rf_io.wr_en && rf_io.wr_addr == rf_io.rd_addr2) ? rf_io.wr_data : regs_q[rf_io.rd_addr2];
  end
  reg_scoreboard u_scb (
    .clk        (clk),
    .rst        (rst),
    .rd_addr1_i (rf_io.rd_addr1),
    .rd_addr2_i (rf_io.rd_addr2),
    .rd_use1_i  (rf_io.rd_use1),
    .rd_use2_i  (rf_io.rd_use2),
    .wr_en_i    (rf_io.wr_en),
    .wr_addr_i  (rf_io.wr_addr),
    .iss_en_i   (rf_io.iss_en),
    .iss_addr_i (rf_io.iss_addr),
    .stall_o    (rf_io.stall),
    .busy_o     (rf_io.busy),
    .err_o      (rf_io.err)
  );
endmodule

// File: tb/tb_reg_file_16b_scb.sv
// tb_reg_file_16b_scb: randomized and directed scoreboard bench against a behavioural register-file model
module tb_reg_file_16b_scb;
  import reg_file_16b_scb_pkg::*;
  typedef struct {
    data_t d1;
    data_t d2;
    logic [7:0] busy;
    logic stall;
    logic err;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int passes = 0;
  int ncyc = 0;
  exp_t q[$];
  data_t m_regs [8];
  bit [7:0] m_busy;
  bit m_err;
  reg_file_16b_scb_if rf();
  reg_file_16b_scb dut (.clk(clk), .rst(rst), .rf_io(rf));
  always #5 clk = ~clk;
  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", n, act, exp);
    else passes++;
  endtask
  function automatic bit m_stall();
    bit h1, h2;
    h1 = rf.rd_use1 && m_busy[rf.rd_addr1] && !(rf.wr_en && rf.wr_addr == rf.rd_addr1);
    h2 = rf.rd_use2 && m_busy[rf.rd_addr2] && !(rf.wr_en && rf.wr_addr == rf.rd_addr2);
    return h1 || h2;
  endfunction
  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_busy = '0;
    m_err = 1'b0;
  endtask
  task automatic drive(bit we, addr_t wa, data_t wd, addr_t a1, addr_t a2, bit u1, bit u2, bit ie, addr_t ia);
    exp_t e;
    rf.wr_en = we; rf.wr_addr = wa; rf.wr_data = wd;
    rf.rd_addr1 = a1; rf.rd_addr2 = a2; rf.rd_use1 = u1; rf.rd_use2 = u2;
    rf.iss_en = ie; rf.iss_addr = ia;
    e.d1 = (we && wa == a1) ? wd : m_regs[a1];
    e.d2 = (we && wa == a2) ? wd : m_regs[a2];
    e.busy = m_busy;
    e.stall = m_stall();
    e.err = m_err;
    q.push_back(e);
  endtask
  task automatic tick();
    bit set;
    set = rf.iss_en && !m_stall();
    @(posedge clk);
    if (rf.wr_en) begin
      if (!m_busy[rf.wr_addr] && !(set && rf.iss_addr == rf.wr_addr)) m_err = 1'b1;
      m_regs[rf.wr_addr] = rf.wr_data;
      m_busy[rf.wr_addr] = 1'b0;
    end
    if (set) m_busy[rf.iss_addr] = 1'b1;
    #1;
  endtask
  task automatic idle(addr_t a1, addr_t a2);
    drive(0, 0, 16'h0, a1, a2, 0, 0, 0, 0);
  endtask
  task automatic mid_reset();
    #2;
    rst = 1'b1;
    m_reset();
    q.delete();
    #1;
    check("rst_rd_data1", 32'(rf.rd_data1), 32'h0);
    check("rst_busy", 32'(rf.busy), 32'h0);
    check("rst_stall", 32'(rf.stall), 32'h0);
    check("rst_err", 32'(rf.err), 32'h0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    int f0;
    if (q.size() != 0) begin
      e = q.pop_front();
      f0 = checks - passes;
      check("mon_rd_data1", 32'(rf.rd_data1), 32'(e.d1));
      check("mon_rd_data2", 32'(rf.rd_data2), 32'(e.d2));
      check("mon_busy", 32'(rf.busy), 32'(e.busy));
      check("mon_stall", 32'(rf.stall), 32'(e.stall));
      check("mon_err", 32'(rf.err), 32'(e.err));
      $display("cycle %0d %s", ncyc, (checks - passes) == f0 ? "PASSED" : "FAILED");
      ncyc++;
    end
  end
  initial begin
    m_reset();
    rf.wr_en = 0; rf.wr_addr = 0; rf.wr_data = 0; rf.rd_addr1 = 0; rf.rd_addr2 = 0;
    rf.rd_use1 = 0; rf.rd_use2 = 0; rf.iss_en = 0; rf.iss_addr = 0;
    #12 rst = 1'b0;
    @(posedge clk);
    #1;
    drive(1, 3, 16'hBEEF, 3, 0, 0, 0, 0, 0);
    tick();
    idle(3, 3);
    #1 check("r3_written", 32'(rf.rd_data1), 32'hBEEF);
    mid_reset();
    drive(0, 0, 16'h0, 0, 0, 0, 0, 1, 4);
    tick();
    drive(0, 0, 16'h0, 0, 4, 0, 1, 0, 0);
    #1 check("hz_busy", 32'(rf.busy), 32'h10);
    check("hz_stall", 32'(rf.stall), 32'h1);
    tick();
    drive(1, 4, 16'h00FF, 0, 4, 0, 1, 0, 0);
    #1 check("hz_wb_stall", 32'(rf.stall), 32'h0);
    check("hz_wb_data2", 32'(rf.rd_data2), 32'h00FF);
    tick();
    idle(0, 4);
    #1 check("hz_cleared", 32'(rf.busy), 32'h0);
    tick();
    drive(0, 0, 16'h0, 0, 0, 0, 0, 1, 6);
    tick();
    drive(1, 6, 16'h6666, 0, 0, 0, 0, 1, 6);
    tick();
    idle(6, 0);
    #1 check("sc_busy6", 32'(rf.busy), 32'h40);
    check("sc_reg6", 32'(rf.rd_data1), 32'h6666);
    check("sc_err", 32'(rf.err), 32'h0);
    tick();
    drive(1, 1, 16'h1111, 0, 0, 0, 0, 0, 0);
    tick();
    idle(1, 0);
    #1 check("pe_err", 32'(rf.err), 32'h1);
    check("pe_reg1", 32'(rf.rd_data1), 32'h1111);
    tick();
    idle(0, 0);
    tick();
    idle(0, 0);
    #1 check("pe_sticky", 32'(rf.err), 32'h1);
    tick();
    drive(1, 5, 16'h1234, 0, 0, 0, 0, 0, 0);
    tick();
    idle(5, 5);
    #1 check("bw_data1", 32'(rf.rd_data1), 32'h1234);
    check("bw_data2", 32'(rf.rd_data2), 32'h1234);
    tick();
    drive(1, 2, 16'hA5A5, 2, 0, 0, 0, 0, 0);
    #1 check("bypass_data1", 32'(rf.rd_data1), 32'hA5A5);
    tick();
    idle(0, 0);
    tick();
    mid_reset();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(1)), addr_t'($urandom_range(7)), data_t'($urandom),
            addr_t'($urandom_range(7)), addr_t'($urandom_range(7)),
            1'($urandom_range(1)), 1'($urandom_range(1)),
            1'($urandom_range(1)), addr_t'($urandom_range(7)));
      tick();
    end
    idle(0, 0);
    @(negedge clk);
    #1 check("queue_drained", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
